// File: rtl/maxicore32_pkg.sv
// Shared types for the maxicore32 memory path: FSM encoding, access widths and
// the lane/alignment rules used by the bus interface.
package maxicore32_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    WidthByte    = 2'd0,
    WidthHalf    = 2'd1,
    WidthWord    = 2'd2,
    WidthIllegal = 2'd3
  } width_e;

  function automatic logic misaligned(logic [1:0] width, logic [1:0] offset);
    case (width)
      WidthByte: return 1'b0;
      WidthHalf: return offset[0];
      WidthWord: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  // Big-endian lanes: byte offset 0 lives in bits 31:24 (strobe bit 3).
  function automatic logic [3:0] lane_strobes(logic [1:0] width, logic [1:0] offset);
    case (width)
      WidthByte: return 4'b1000 >> offset;
      WidthHalf: return offset[1] ? 4'b0011 : 4'b1100;
      WidthWord: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] place_data(logic [1:0] width, logic [31:0] data);
    case (width)
      WidthByte: return {4{data[7:0]}};
      WidthHalf: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_extract.sv
// Combinational read path: picks the addressed big-endian lane out of a memory
// word and zero- or sign-extends it to 32 bits.
module bus_lane_extract
  import maxicore32_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];

    case (width)
      WidthByte: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      WidthHalf: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/bus_interface.sv
// CPU-to-memory bus interface: IDLE/ACCESS/DONE sequencer with optional wait
// states, big-endian byte-lane placement and alignment checking.
module bus_interface
  import maxicore32_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        done,
  output logic        bus_error,
  output logic [31:0] result,
  output logic        mem_cs,
  output logic        mem_read,
  output logic        mem_write,
  output logic [29:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic [3:0]  mem_strobes
);

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  bus_state_e  state_q, state_d;
  logic [3:0]  wait_q;
  logic [1:0]  width_q, offset_q;
  logic        signed_q, write_q, error_q;
  logic [29:0] address_q;
  logic [31:0] data_out_q, result_q, read_value;
  logic [3:0]  strobes_q;
  logic        req_bad;

  assign req_bad = misaligned(req_width, req_address[1:0]);

  bus_lane_extract u_lane_extract (
    .word     (mem_data_in),
    .width    (width_q),
    .offset   (offset_q),
    .sign_ext (signed_q),
    .result   (read_value)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (req) state_d = req_bad ? StDone : StAccess;
      StAccess: if (wait_q == 4'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wait_q     <= 4'd0;
      width_q    <= 2'd0;
      offset_q   <= 2'd0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      error_q    <= 1'b0;
      address_q  <= '0;
      data_out_q <= '0;
      strobes_q  <= 4'd0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (req) begin
            if (req_bad) begin
              error_q  <= 1'b1;
              result_q <= '0;
            end else begin
              // Snapshot the request; req_* may change freely from here on.
              error_q    <= 1'b0;
              wait_q     <= WaitInit;
              width_q    <= req_width;
              offset_q   <= req_address[1:0];
              signed_q   <= req_signed;
              write_q    <= req_write;
              address_q  <= req_address[31:2];
              data_out_q <= place_data(req_width, req_data);
              strobes_q  <= lane_strobes(req_width, req_address[1:0]);
            end
          end
        end
        StAccess: begin
          if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
          else                result_q <= write_q ? '0 : read_value;
        end
        default: ;
      endcase
    end
  end

  assign mem_cs       = (state_q == StAccess);
  assign mem_read     = mem_cs & ~write_q;
  assign mem_write    = mem_cs & write_q;
  assign done         = (state_q == StDone);
  assign bus_error    = done & error_q;
  assign result       = result_q;
  assign mem_address  = address_q;
  assign mem_data_out = data_out_q;
  assign mem_strobes  = strobes_q;

endmodule

// File: tb/tb_bus_interface.sv
// Bench for bus_interface: directed and random accesses on a zero-wait and a
// three-wait instance, checked against a byte-addressed big-endian memory model.
module tb_bus_interface;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req3;
  logic        req_write, req_signed;
  logic [1:0]  req_width;
  logic [31:0] req_address, req_data;

  logic        done0, err0, cs0, rd0, wr0;
  logic [31:0] res0, dout0, din0;
  logic [29:0] addr0;
  logic [3:0]  strb0;
  logic        done3, err3, cs3, rd3, wr3;
  logic [31:0] res3, dout3, din3;
  logic [29:0] addr3;
  logic [3:0]  strb3;

  logic [31:0] phys  [2][64];
  logic [7:0]  ref_b [2][256];
  logic        mem_load;
  int          n_pass = 0;
  int          n_total = 0;
  int          cur_sel = 0;

  always #5 clock = ~clock;

  bus_interface #(.WAIT_STATES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req0), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_address(req_address),
    .req_data(req_data), .done(done0), .bus_error(err0), .result(res0),
    .mem_cs(cs0), .mem_read(rd0), .mem_write(wr0), .mem_address(addr0),
    .mem_data_out(dout0), .mem_data_in(din0), .mem_strobes(strb0)
  );

  bus_interface #(.WAIT_STATES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req3), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_address(req_address),
    .req_data(req_data), .done(done3), .bus_error(err3), .result(res3),
    .mem_cs(cs3), .mem_read(rd3), .mem_write(wr3), .mem_address(addr3),
    .mem_data_out(dout3), .mem_data_in(din3), .mem_strobes(strb3)
  );

  assign din0 = phys[0][addr0[5:0]];
  assign din3 = phys[1][addr3[5:0]];

  function automatic logic [31:0] init_word(int i);
    return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Memory as seen by the DUTs: written on the negedge while selected.
  always @(negedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) begin
        phys[0][i] <= init_word(i);
        phys[1][i] <= init_word(i);
      end
    end else begin
      if (cs0 && wr0) phys[0][addr0[5:0]] <= merge(phys[0][addr0[5:0]], dout0, strb0);
      if (cs3 && wr3) phys[1][addr3[5:0]] <= merge(phys[1][addr3[5:0]], dout3, strb3);
    end
  end

  logic        c_done, c_err, c_cs, c_rd, c_wr;
  logic [31:0] c_res, c_dout;
  logic [29:0] c_addr;
  logic [3:0]  c_strb;

  always_comb begin
    if (cur_sel == 0) begin
      c_done = done0; c_err = err0; c_cs = cs0; c_rd = rd0; c_wr = wr0;
      c_res = res0; c_dout = dout0; c_addr = addr0; c_strb = strb0;
    end else begin
      c_done = done3; c_err = err3; c_cs = cs3; c_rd = rd3; c_wr = wr3;
      c_res = res3; c_dout = dout3; c_addr = addr3; c_strb = strb3;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(int sel, logic [31:0] a);
    logic [7:0] base = {a[7:2], 2'b00};
    return {ref_b[sel][base], ref_b[sel][base + 8'd1], ref_b[sel][base + 8'd2],
            ref_b[sel][base + 8'd3]};
  endfunction

  // One request/response transaction, every observable compared against the model.
  task automatic do_access(input int sel, input logic wr, input logic [1:0] w,
                           input logic sg, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] o_res, output logic [3:0] o_strb,
                           output logic [31:0] o_dout);
    int          n, k, cs_n, lat;
    logic        err, got;
    logic [3:0]  e_strb;
    logic [31:0] e_dout, e_res;
    longint      v;

    n   = (w == 2'd3) ? 4 : (1 << w);
    err = (w == 2'd3) || ((int'(a[1:0]) % n) != 0);
    e_strb = 4'd0;
    if (!err) for (int i = 0; i < n; i++) e_strb[3 - (int'(a[1:0]) + i)] = 1'b1;
    for (int i = 0; i < 4; i++) e_dout[8*i +: 8] = d[8*(i % n) +: 8];
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | longint'(ref_b[sel][a[7:0] + 8'(i)]);
    if (sg && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    e_res = (err || wr) ? 32'd0 : v[31:0];
    lat   = err ? 1 : ((sel == 0) ? 0 : 3) + 2;

    cur_sel = sel;
    @(negedge clock);
    req_write = wr; req_width = w; req_signed = sg; req_address = a; req_data = d;
    if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
    k = 0; cs_n = 0; got = 1'b0;
    o_res = '0; o_strb = '0; o_dout = '0;
    while (!got && k < 40) begin
      @(negedge clock);
      k++;
      if (c_cs) begin
        cs_n++;
        check("mem_address", {2'b00, c_addr}, {2'b00, a[31:2]});
        check("mem_strobes", {28'd0, c_strb}, {28'd0, e_strb});
        check("rd_wr_select", {30'd0, c_rd, c_wr}, wr ? 32'd1 : 32'd2);
        if (wr) check("mem_data_out", c_dout, e_dout);
        o_strb = c_strb; o_dout = c_dout;
      end
      if (c_done) begin
        got = 1'b1;
        check("latency", 32'(k), 32'(lat));
        check("bus_error", {31'd0, c_err}, {31'd0, err});
        check("result", c_res, e_res);
        o_res = c_res;
      end
      if (k == 1) begin
        // Drop req and scramble the request fields; the DUT must hold its snapshot.
        req0 = 1'b0; req3 = 1'b0;
        req_address = $urandom; req_data = $urandom; req_width = 2'($urandom);
        req_write = 1'($urandom); req_signed = 1'($urandom);
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("cs_cycles", 32'(cs_n), err ? 32'd0 : 32'(lat - 1));
    @(negedge clock);
    check("done_one_cycle", {31'd0, c_done}, 32'd0);
    if (wr && !err) for (int i = 0; i < n; i++) ref_b[sel][a[7:0] + 8'(i)] = d[8*(n-1-i) +: 8];
    check("mem_word", phys[sel][a[7:2]], ref_word(sel, a));
  endtask

  initial begin
    logic [31:0] r, dq;
    logic [3:0]  s;
    logic [31:0] a, d;
    logic [1:0]  w;
    int          first_done, second_done;

    reset_n = 1'b0; mem_load = 1'b1; req0 = 1'b0; req3 = 1'b0;
    req_write = 1'b0; req_width = 2'd0; req_signed = 1'b0; req_address = '0; req_data = '0;
    for (int sidx = 0; sidx < 2; sidx++)
      for (int i = 0; i < 64; i++)
        {ref_b[sidx][4*i], ref_b[sidx][4*i+1], ref_b[sidx][4*i+2], ref_b[sidx][4*i+3]} =
            init_word(i);
    repeat (2) @(negedge clock);
    check("reset_done", {31'd0, done0}, 32'd0);
    check("reset_cs", {29'd0, cs0, rd0, wr0}, 32'd0);
    check("reset_result", res0, 32'd0);
    check("reset_strobes", {28'd0, strb0}, 32'd0);
    check("reset_addr", {2'b00, addr0}, 32'd0);
    check("reset_dout", dout0, 32'd0);
    mem_load = 1'b0;
    reset_n  = 1'b1;

    // Word write then read back.
    do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, s, dq);
    check("word_wr_strobes", {28'd0, s}, 32'hF);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, s, dq);
    check("word_rd_result", r, 32'hDEADBEEF);

    // Signed and unsigned byte reads of the last lane.
    do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h123456F0, r, s, dq);
    do_access(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, r, s, dq);
    check("sbyte_strobes", {28'd0, s}, 32'h1);
    check("sbyte_result", r, 32'hFFFFFFF0);
    do_access(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r, s, dq);
    check("ubyte_result", r, 32'h000000F0);

    // Halfword write into the low half preserves the upper half.
    do_access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11112222, r, s, dq);
    do_access(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, r, s, dq);
    check("half_dout", dq, 32'hABCDABCD);
    check("half_strobes", {28'd0, s}, 32'h3);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, s, dq);
    check("half_preserve", r, 32'h1111ABCD);

    // Misaligned word read: error path.
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, r, s, dq);
    check("misalign_result", r, 32'd0);

    // Three wait states.
    do_access(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BADF00D, r, s, dq);
    do_access(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, r, s, dq);
    check("ws3_result", r, 32'h0BADF00D);

    // Reset asserted mid-ACCESS, before the memory's negedge write.
    cur_sel = 0;
    @(negedge clock);
    req_write = 1'b1; req_width = 2'd2; req_signed = 1'b0;
    req_address = 32'h30; req_data = 32'hCAFEF00D; req0 = 1'b1;
    @(posedge clock);
    #2;
    check("pre_reset_cs", {31'd0, cs0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_cs", {29'd0, cs0, rd0, wr0}, 32'd0);
    check("rst_done", {30'd0, done0, err0}, 32'd0);
    check("rst_outputs", dout0 | res0 | {2'b00, addr0} | {28'd0, strb0}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("post_reset_idle", {30'd0, cs0, done0}, 32'd0);
    end
    check("rst_no_write", phys[0][12], ref_word(0, 32'h30));

    // req held through DONE is taken again as a fresh access.
    @(negedge clock);
    req_write = 1'b0; req_width = 2'd2; req_signed = 1'b0; req_address = 32'h10; req0 = 1'b1;
    first_done = 0; second_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (done0) begin
        if (first_done == 0) first_done = k;
        else if (second_done == 0) second_done = k;
      end
      if (k == 5) req0 = 1'b0;
    end
    check("hold_first_done", 32'(first_done), 32'd2);
    check("hold_second_done", 32'(second_done), 32'd5);

    // Random traffic, mostly aligned, some misaligned or illegal.
    for (int i = 0; i < 40; i++) begin
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd2) a[1:0] = 2'b00;
      end
      d = $urandom;
      do_access((i % 4 == 3) ? 1 : 0, 1'($urandom), w, 1'($urandom), a, d, r, s, dq);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
